// File: rtl/nibble_serial_sub_if.sv
// Controller-side handshake and operand/result bundle for nibble_serial_sub.
// The ovf signal exists only when SIGNED_OVF_EN is defined.
interface nibble_serial_sub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
`ifdef SIGNED_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, borrow, zero, ovf);
    modport slave  (input start, a, b, output busy, done, diff, borrow, zero, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, borrow, zero);
    modport slave  (input start, a, b, output busy, done, diff, borrow, zero);
`endif
endinterface

// File: rtl/nibble_serial_sub.sv
// Serial WIDTH-bit subtractor: one 4-bit two's-complement slice reused per clock.
// Optional signed-overflow output enabled by defining SIGNED_OVF_EN.
module nibble_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_sub_if.slave    bus
);
    localparam int NIB = 4;
    localparam int K   = WIDTH / NIB;
    localparam int CW  = $clog2(K);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             busy_r, done_r, borrow_r, zero_r;
    logic [NIB:0]     s5;
    logic             accept, last;

    // The slice computes a + ~b + carry; the result register fills from the top.
    always_comb begin
        s5       = {1'b0, a_sh[NIB-1:0]} + {1'b0, ~b_sh[NIB-1:0]} + {{NIB{1'b0}}, carry};
        res_next = {s5[NIB-1:0], res[WIDTH-1:NIB]};
        accept   = (state == IDLE) && bus.start;
        last     = (state == RUN) && (cnt == CW'(K - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            carry    <= 1'b1;
            cnt      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            borrow_r <= 1'b0;
            zero_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                a_sh     <= bus.a;
                b_sh     <= bus.b;
                res      <= '0;
                carry    <= 1'b1;
                cnt      <= '0;
                busy_r   <= 1'b1;
                borrow_r <= 1'b0;
                zero_r   <= 1'b0;
            end else if (state == RUN) begin
                a_sh  <= a_sh >> NIB;
                b_sh  <= b_sh >> NIB;
                res   <= res_next;
                carry <= s5[NIB];
                cnt   <= cnt + CW'(1);
                if (last) begin
                    borrow_r <= ~s5[NIB];
                    zero_r   <= (res_next == '0);
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                end
            end
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.diff   = res;
    assign bus.borrow = borrow_r;
    assign bus.zero   = zero_r;

`ifdef SIGNED_OVF_EN
    logic a_msb, b_msb, ovf_r;

    // Sign bits are captured up front because the operand registers are consumed by shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
            ovf_r <= 1'b0;
        end else if (last) begin
            ovf_r <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
        end
    end

    assign bus.ovf = ovf_r;
`endif
endmodule
